// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-image loader: word width, default magic and FSM encoding.
package prog_loader_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] MAGIC_DEFAULT = 32'hC0DE_0001;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    SUM  = 3'd4,
    RUN  = 3'd5,
    ERR  = 3'd6
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Image stream in and instruction-memory write port out, bundled for the loader.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  import prog_loader_pkg::*;

  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic              imem_wen;
  logic [ADDR_W-1:0] imem_waddr;
  logic [WORD_W-1:0] imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_wen, imem_waddr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_wen, imem_waddr, imem_wdata
  );

endinterface

// File: rtl/prog_loader_csum.sv
// Running modulo-2^32 sum of the image payload words.
module prog_loader_csum
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              add_en,
  input  logic [WORD_W-1:0] data,
  output logic [WORD_W-1:0] sum
);

  // Carry out of bit 31 is dropped by the fixed-width add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + data;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Verifies a streamed boot image (magic, length, payload, checksum), writes the payload
// into instruction memory and releases the core only after a fully verified load.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W = 10,
  parameter logic [WORD_W-1:0] MAGIC  = MAGIC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  prog_loader_if.slave    bus,
  output logic            cpu_run,
  output logic            error,
  output logic [ADDR_W:0] words_loaded
);

  localparam int unsigned       CNT_W    = ADDR_W + 1;
  localparam logic [WORD_W-1:0] CAPACITY = WORD_W'(64'd1 << ADDR_W);

  state_t            state;
  state_t            next_state;
  logic              accept_c;
  logic              len_bad_c;
  logic              len_ld_c;
  logic              data_wr_c;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] sum;

  assign accept_c  = bus.in_valid & bus.in_ready;
  assign len_bad_c = (bus.in_data == '0) || (bus.in_data > CAPACITY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    len_ld_c   = 1'b0;
    data_wr_c  = 1'b0;
    case (state)
      IDLE: if (start) next_state = HDR;
      HDR:  if (accept_c) next_state = (bus.in_data == MAGIC) ? LEN : ERR;
      LEN: begin
        if (accept_c) begin
          if (len_bad_c) begin
            next_state = ERR;
          end else begin
            next_state = DATA;
            len_ld_c   = 1'b1;
          end
        end
      end
      DATA: begin
        if (accept_c) begin
          data_wr_c = 1'b1;
          if ((cnt + CNT_W'(1)) == len) next_state = SUM;
        end
      end
      SUM:      if (accept_c) next_state = (bus.in_data == sum) ? RUN : ERR;
      RUN, ERR: if (start) next_state = HDR;
      default:  next_state = IDLE;
    endcase
  end

  // Status and handshake outputs are registered from the next state so they track it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.in_ready    <= 1'b0;
      bus.imem_wen    <= 1'b0;
      bus.imem_waddr  <= '0;
      bus.imem_wdata  <= '0;
      cpu_run         <= 1'b0;
      error           <= 1'b0;
      words_loaded    <= '0;
      len             <= '0;
      cnt             <= '0;
    end else begin
      bus.in_ready <= (next_state == HDR) || (next_state == LEN) ||
                      (next_state == DATA) || (next_state == SUM);
      bus.imem_wen <= data_wr_c;
      cpu_run      <= (next_state == RUN);
      error        <= (next_state == ERR);

      if (len_ld_c) begin
        len <= CNT_W'(bus.in_data);
        cnt <= '0;
      end else if (data_wr_c) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (data_wr_c) begin
        bus.imem_waddr <= cnt[ADDR_W-1:0];
        bus.imem_wdata <= bus.in_data;
        words_loaded   <= words_loaded + CNT_W'(1);
      end else if ((state == HDR) && (next_state == LEN)) begin
        words_loaded <= '0;
      end
    end
  end

  prog_loader_csum u_csum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (len_ld_c),
    .add_en (data_wr_c),
    .data   (bus.in_data),
    .sum    (sum)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a reference image parser predicts writes and outcome.
module tb_prog_loader;

  localparam int unsigned AW    = 10;
  localparam logic [31:0] MAGIC = 32'hC0DE_0001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cpu_run;
  logic          error;
  logic [AW:0]   words_loaded;

  prog_loader_if #(.ADDR_W(AW)) bus ();

  prog_loader #(.ADDR_W(AW), .MAGIC(MAGIC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .cpu_run      (cpu_run),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            wl;
  } wr_t;

  wr_t         sb[$];
  int          wr_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          exp_wl = 0;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: parse an image by its rules; report outcome, words consumed, payload count.
  function automatic void model(input logic [31:0] img[$], output bit ok,
                                output int consumed, output int nwr);
    logic [31:0] n;
    logic [31:0] s;
    ok = 1'b0; consumed = 1; nwr = 0;
    if (img[0] != MAGIC) return;
    n = img[1];
    consumed = 2;
    if (n == 0 || n > 32'd1024) return;
    s = 0;
    for (int i = 0; i < int'(n); i++) s += img[2 + i];
    nwr = int'(n);
    consumed = nwr + 3;
    ok = (img[nwr + 2] == s);
  endfunction

  // Monitor: every write is popped against the scoreboard; idle cycles must hold the bus.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_addr = '0;
      last_data = '0;
    end else if (bus.imem_wen) begin
      wr_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("waddr", bus.imem_waddr, e.addr);
        chk("wdata", bus.imem_wdata, e.data);
        chk("words_loaded_at_write", words_loaded, e.wl);
      end
      last_addr = bus.imem_waddr;
      last_data = bus.imem_wdata;
    end else begin
      chk("waddr_hold", bus.imem_waddr, last_addr);
      chk("wdata_hold", bus.imem_wdata, last_data);
    end
  end

  task automatic send_word(input logic [31:0] w, input int thr, input bit glitch);
    int guard;
    guard = 0;
    if (thr == 2 || (thr == 1 && $urandom_range(0, 1) == 1)) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    start        = glitch;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 0, 1);
      bus.in_valid = 1'b0;
      start = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic pulse_start(input string tag);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({tag, "_ready_after_start"}, bus.in_ready, 1);
    chk({tag, "_run_dropped"}, cpu_run, 0);
    chk({tag, "_err_dropped"}, error, 0);
  endtask

  task automatic run_load(input string tag, input logic [31:0] img[$], input int thr,
                          input int glitch_idx);
    bit ok;
    int cons;
    int nwr;
    wr_t e;
    model(img, ok, cons, nwr);
    for (int i = 0; i < nwr; i++) begin
      e.addr = AW'(i);
      e.data = img[2 + i];
      e.wl   = i + 1;
      sb.push_back(e);
    end
    if (img[0] == MAGIC) exp_wl = nwr;
    pulse_start(tag);
    wr_cyc.delete();
    for (int i = 0; i < cons; i++) send_word(img[i], thr, (i == glitch_idx));
    chk({tag, "_cpu_run"}, cpu_run, ok);
    chk({tag, "_error"}, error, !ok);
    chk({tag, "_ready_low"}, bus.in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_sb_drained"}, sb.size(), 0);
    chk({tag, "_words_loaded"}, words_loaded, exp_wl);
    chk({tag, "_cpu_run_held"}, cpu_run, ok);
    chk({tag, "_error_held"}, error, !ok);
    if (thr == 0 && nwr > 0) begin
      chk({tag, "_write_count"}, wr_cyc.size(), nwr);
      if (wr_cyc.size() == nwr)
        chk({tag, "_no_bubbles"}, wr_cyc[nwr - 1] - wr_cyc[0], nwr - 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_wen"}, bus.imem_wen, 0);
    chk({tag, "_waddr"}, bus.imem_waddr, 0);
    chk({tag, "_wdata"}, bus.imem_wdata, 0);
    chk({tag, "_cpu_run"}, cpu_run, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_words_loaded"}, words_loaded, 0);
  endtask

  task automatic random_loads(input int count);
    logic [31:0] img[$];
    logic [31:0] s;
    logic [31:0] w;
    int n;
    int kind;
    for (int t = 0; t < count; t++) begin
      img.delete();
      n    = $urandom_range(1, 16);
      kind = $urandom_range(0, 5);
      s    = 0;
      img.push_back((kind == 1) ? $urandom : MAGIC);
      if (kind == 2) img.push_back(($urandom_range(0, 1) == 1) ? 32'd0 : 32'(1025 + $urandom_range(0, 100)));
      else           img.push_back(32'(n));
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        img.push_back(w);
        s += w;
      end
      img.push_back((kind == 3) ? (s ^ (32'd1 << $urandom_range(0, 31))) : s);
      run_load("rand", img, int'($urandom_range(0, 1)), -1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] img[$];
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_reset_ready", bus.in_ready, 0);
    chk("idle_after_reset_run", cpu_run, 0);

    img = '{MAGIC, 32'd3, 32'h11, 32'h22, 32'h33, 32'h66};
    run_load("nominal", img, 0, -1);

    img = '{32'hDEAD_BEEF};
    run_load("bad_magic", img, 0, -1);

    img = '{MAGIC, 32'd3, 32'h11, 32'h22, 32'h33, 32'h67};
    run_load("bad_sum", img, 0, -1);
    img = '{MAGIC, 32'd3, 32'h11, 32'h22, 32'h33, 32'h66};
    run_load("reload", img, 0, -1);

    img = '{MAGIC, 32'd0};
    run_load("len_zero", img, 0, -1);
    img = '{MAGIC, 32'd1025};
    run_load("len_over", img, 0, -1);

    img.delete();
    img.push_back(MAGIC);
    img.push_back(32'd1024);
    for (int i = 0; i < 1024; i++) img.push_back(32'hFFFF_FFFF);
    img.push_back(32'hFFFF_FC00);
    run_load("len_full", img, 0, -1);

    img = '{MAGIC, 32'd3, 32'h11, 32'h22, 32'h33, 32'h66};
    run_load("throttled", img, 2, -1);

    img = '{MAGIC, 32'd3, 32'hA, 32'hB, 32'hC, 32'h21};
    run_load("start_in_data", img, 0, 3);

    // Abort after two of three payload words.
    pulse_start("abort");
    send_word(MAGIC, 0, 1'b0);
    send_word(32'd3, 0, 1'b0);
    begin
      wr_t e;
      e.addr = AW'(0); e.data = 32'h11; e.wl = 1; sb.push_back(e);
      e.addr = AW'(1); e.data = 32'h22; e.wl = 2; sb.push_back(e);
    end
    send_word(32'h11, 0, 1'b0);
    send_word(32'h22, 0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check_reset_outputs("abort_rst");
    chk("abort_sb_drained", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_wl = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_run", cpu_run, 0);
    chk("abort_idle_ready", bus.in_ready, 0);
    img = '{MAGIC, 32'd3, 32'h11, 32'h22, 32'h33, 32'h66};
    run_load("after_abort", img, 0, -1);

    random_loads(30);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the instruction-memory word-address width (capacity 2^ADDR_W words).
REQ-002 SHALL have parameter MAGIC, default 32'hC0DE_0001, meaning the required first word of every image.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a new load.
REQ-006 SHALL have port in_valid  input  1  image word on in_data is valid.
REQ-007 SHALL have port in_data  input  32  image word.
REQ-008 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-009 SHALL have port imem_wen  output  1  instruction-memory write strobe.
REQ-010 SHALL have port imem_waddr  output  ADDR_W  instruction-memory word address.
REQ-011 SHALL have port imem_wdata  output  32  instruction-memory write data.
REQ-012 SHALL have port cpu_run  output  1  core released from reset; high only after a verified load.
REQ-013 SHALL have port error  output  1  last load failed.
REQ-014 SHALL have port words_loaded  output  ADDR_W+1  instruction words written in the current or last load.

Function
REQ-015 SHALL treat a word as accepted only in a cycle where in_valid and in_ready are both high.
REQ-016 SHALL accept an image of the form: MAGIC, length N, then N instruction words, then a checksum equal to the modulo-2^32 sum of the N instruction words.
REQ-017 SHALL implement states IDLE, HDR, LEN, DATA, SUM, RUN and ERR, and SHALL drive in_ready high exactly in HDR, LEN, DATA and SUM.
REQ-018 In IDLE, SHALL go to HDR on start.
REQ-019 In HDR, on acceptance SHALL go to LEN if the word equals MAGIC, otherwise to ERR.
REQ-020 In LEN, on acceptance SHALL go to ERR if N==0 or N>2^ADDR_W; otherwise SHALL latch N, clear the address counter, clear the checksum accumulator, and go to DATA.
REQ-021 In DATA, each accepted word SHALL be written at address k, where k counts 0..N-1, and SHALL be added to the accumulator.
REQ-022 In DATA, after the N-th accepted word, SHALL go to SUM.
REQ-023 In SUM, on acceptance SHALL go to RUN if the word equals the accumulator, otherwise to ERR.
REQ-024 Writes SHALL be registered: imem_wen is high for exactly one cycle, in the cycle after acceptance, with imem_waddr=k and imem_wdata=the accepted word.
REQ-025 When no write is pending, imem_wen SHALL be 0, and imem_waddr and imem_wdata SHALL hold their last values.
REQ-026 Back-to-back acceptances SHALL yield back-to-back writes, with zero bubbles and one word per cycle sustained.
REQ-027 words_loaded SHALL increment together with each imem_wen pulse, SHALL clear on the transition into LEN, and SHALL hold its value in RUN and ERR.
REQ-028 cpu_run SHALL be registered and high exactly while the state is RUN; it rises the cycle after the checksum is accepted.
REQ-029 error SHALL be registered and high exactly while the state is ERR.
REQ-030 start in RUN or ERR SHALL move to HDR next cycle, dropping cpu_run or error in that same cycle.
REQ-031 start in HDR, LEN, DATA or SUM SHALL be ignored.
REQ-032 When in_valid is low in HDR, LEN, DATA or SUM, SHALL hold state and counters unchanged, with no timeout.
REQ-033 When N==2^ADDR_W, the address counter SHALL reach 2^ADDR_W-1 without wrapping, and words_loaded SHALL reach 2^ADDR_W.
REQ-034 The checksum SHALL wrap modulo 2^32, with carry discarded.

Reset
REQ-035 While rst_n is low, state SHALL be IDLE, and in_ready, imem_wen, cpu_run and error SHALL be 0.
REQ-036 While rst_n is low, imem_waddr, imem_wdata, words_loaded, the accumulator and the counters SHALL be 0.
REQ-037 Reset asserted mid-load SHALL abort the load immediately and without any further write; no partial image SHALL ever assert cpu_run.
REQ-038 After reset release, SHALL remain in IDLE until start.

Structure
REQ-039 The shared package SHALL hold the state encoding (3-bit, IDLE=0 .. ERR=6), the MAGIC default and the image word width (32).
REQ-040 SHALL contain one sub-module, prog_loader_csum: a 32-bit accumulator with clear/add-enable inputs and the sum as output.
REQ-041 All remaining logic SHALL be flat in prog_loader.

Verification
REQ-042 Nominal load (ADDR_W=10): start, then stream C0DE0001, 3, 00000011, 00000022, 00000033, 00000066 with valid held high -> writes at addresses 0/1/2 with data 11/22/33 on consecutive cycles, words_loaded=3, cpu_run=1 one cycle after the last word, error=0.
REQ-043 Bad magic: first word DEADBEEF -> ERR next cycle, error=1, no imem_wen, cpu_run=0.
REQ-044 Bad checksum: same image as the nominal load but checksum 00000067 -> 3 writes occur, then error=1 and cpu_run=0; a following start plus the correct image gives cpu_run=1.
REQ-045 Length bounds: N=0 -> ERR; N=1025 -> ERR; N=1024 with all words FFFFFFFF and checksum FFFFFC00 -> last write at address 1023, words_loaded=1024, cpu_run=1.
REQ-046 Throttling and reset: in_valid toggling 1/0 during DATA -> writes only follow accepted words; rst_n pulsed low after 2 of 3 data words -> all outputs 0, and no cpu_run until a full reload.
REQ-047 start during DATA -> ignored, and the load completes normally.
